// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial NAND adder: FSM encoding and default width.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage : serial_add_pkg

// File: rtl/fa_nand.sv
// One-bit full adder built from nine 2-input NAND gates.
module fa_nand (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic n1, n2, n3, x1, n5, n6, n7;

  // First four gates form a XOR b; n1 doubles as the generate term for cout.
  assign n1   = ~(a & b);
  assign n2   = ~(a & n1);
  assign n3   = ~(b & n1);
  assign x1   = ~(n2 & n3);
  assign n5   = ~(x1 & cin);
  assign n6   = ~(x1 & n5);
  assign n7   = ~(cin & n5);
  assign sum  = ~(n6 & n7);
  assign cout = ~(n1 & n5);

endmodule : fa_nand

// File: rtl/serial_adder_nand.sv
// LSB-first bit-serial adder: one NAND full-adder slice per cycle, carry held in a flop,
// start/busy/done handshake with registered outputs.
module serial_adder_nand
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, acc_d, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             s_w, c_w;

  fa_nand u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (s_w),
    .cout (c_w)
  );

  // The final slice's sum bit completes the accumulator in the same edge it is latched to sum.
  assign acc_d = {s_w, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q   <= acc_d;
          a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
          carry_q <= c_w;
          if (cnt_q == LAST) begin
            sum_q   <= acc_d;
            cout_q  <= c_w;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder_nand

// File: tb/tb_serial_adder_nand.sv
// Self-checking bench for serial_adder_nand: directed table, random ops against a+b+cin,
// and hand-written sequences for ignored start, mid-operation reset and back-to-back starts.
module tb_serial_adder_nand;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0;

  always #5 clk = ~clk;

  serial_adder_nand #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Start one addition, then follow it cycle by cycle through SHIFT and DONE.
  task automatic do_add(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W-1:0] es, input logic ec);
    int unsigned done_seen;
    done_seen = 0;
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Operands are captured; scrambling them must not affect the result.
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int j = 0; j <= int'(W) + 1; j++) begin
      if (j > 0) @(negedge clk);
      if (j < int'(W)) begin
        check("busy_shift", 32'(busy), 32'd1);
        check("done_shift", 32'(done), 32'd0);
        check("sum_hold", 32'(sum), 32'(prev_sum));
        check("cout_hold", 32'(cout), 32'(prev_cout));
      end else if (j == int'(W)) begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
      end else begin
        check("done_width", 32'(done), 32'd0);
      end
      if (done) done_seen++;
    end
    check("done_count", done_seen, 32'd1);
    prev_sum  = es;
    prev_cout = ec;
  endtask

  initial begin
    vec_t vecs[5];
    logic [W:0] model;
    logic [W-1:0] ra, rb;
    logic rc;
    int unsigned done_seen, last_done, ndone, cyc;
    logic prev_done;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, s: 8'h96, c: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, c: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b1, s: 8'h01, c: 1'b1};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++)
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_add(ra, rb, rc, model[W-1:0], model[W]);
    end

    // Second start during SHIFT, with a changed operand, must be ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    for (int j = 0; j < int'(W) + 8; j++) begin
      if (j == 2) begin start = 1'b1; a = 8'hAA; end
      if (j == 5) start = 1'b0;
      if (done) done_seen++;
      @(negedge clk);
    end
    check("ign_done_count", done_seen, 32'd1);
    check("ign_sum", 32'(sum), 32'h30);
    check("ign_cout", 32'(cout), 32'd0);
    prev_sum = 8'h30; prev_cout = 1'b0;

    // Reset during SHIFT clears everything at once and suppresses done.
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("mid_rst_no_done", done_seen, 32'd0);
    rst_n = 1'b1;
    prev_sum = '0; prev_cout = 1'b0;
    do_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // start held high: one operation accepted every W+2 cycles.
    @(negedge clk);
    a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
    last_done = 0; ndone = 0; prev_done = 1'b0;
    for (cyc = 1; cyc <= 5 * (W + 2); cyc++) begin
      @(negedge clk);
      if (done) begin
        if (ndone > 0) check("b2b_spacing", cyc - last_done, W + 2);
        check("b2b_sum", 32'(sum), 32'h78);
        last_done = cyc;
        ndone++;
      end
      if (done && prev_done) check("b2b_width", 32'd2, 32'd1);
      if (ndone > 0 && !done) check("b2b_stable", 32'(sum), 32'h78);
      prev_done = done;
    end
    check("b2b_count", ndone, 32'd5);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_adder_nand
